// File: rtl/negedge_word_receiver.sv
// negedge_word_receiver
// Posedge-side capture of a negedge-launched word stream into a small
// first-word-fall-through queue, drained by a valid/ready consumer.
// Optional build macro: NEGRX_OVF_STICKY_EN adds a sticky overflow flag
// that records any word offered while the queue was full.
module negedge_word_receiver #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             push_c, pop_c;

    // Handshake decode, pointer/occupancy update and next head word.
    always_comb begin
        push_c      = in_valid & in_ready_q;
        pop_c       = out_ready & out_valid_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        out_data_d  = '0;

        if (push_c) wp_d = wp_q + PTR_W'(1);
        if (pop_c)  rp_d = rp_q + PTR_W'(1);

        if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
        else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);

        in_ready_d  = (count_d != CNT_W'(DEPTH));
        out_valid_d = (count_d != CNT_W'(0));

        // The new head is the word being written this edge when the
        // read pointer lands on the slot currently being filled.
        if (out_valid_d) begin
            if (push_c && (rp_d == wp_q)) out_data_d = in_data;
            else                          out_data_d = mem_q[rp_d];
        end
    end

    // Storage array; contents need no reset since out_data is gated.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wp_q] <= in_data;
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;

`ifdef NEGRX_OVF_STICKY_EN
    logic ovf_q;

    // Sticky flag: set on the first word offered while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       ovf_q <= 1'b0;
        else if (in_valid && !in_ready_q) ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_negedge_word_receiver.sv
// Self-checking bench for negedge_word_receiver: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_negedge_word_receiver;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [2:0]       count;
    logic             ovf;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain FIFO of accepted words plus a sticky flag.
    logic [WIDTH-1:0] mq [$];
    bit               ovf_m;

    negedge_word_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Compare every output against the model.
    task automatic check_all(input string tag);
        logic [31:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : 32'h0;
        chk({tag, ".count"},     32'(count),     32'(mq.size()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() != DEPTH));
        chk({tag, ".out_data"},  out_data,       exp_data);
        chk({tag, ".ovf"},       32'(ovf),       32'(ovf_m));
    endtask

    // One cycle: drive at negedge, model the posedge, check at next negedge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input string tag);
        bit full, push, pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        full = (mq.size() == DEPTH);
        push = v && !full;
        pop  = r && (mq.size() != 0);
`ifdef NEGRX_OVF_STICKY_EN
        if (v && full) ovf_m = 1'b1;
`endif
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        ovf_m = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        mq.delete();
        ovf_m = 1'b0;

        // Reset / idle
        do_reset();
        @(negedge clk);
        check_all("reset");

        // Single word then pop
        step(1'b1, 32'hDEADBEEF, 1'b0, "single_push");
        chk("single.data", out_data, 32'hDEADBEEF);
        step(1'b0, 32'h0, 1'b1, "single_pop");
        chk("single.empty_data", out_data, 32'h0);

        // Fill, partial drain, refill across wrap, drain
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, "fill");
        chk("fill.in_ready", 32'(in_ready), 32'h0);
        chk("fill.count", 32'(count), 32'h4);
        step(1'b0, 32'h0, 1'b1, "pop1");
        step(1'b0, 32'h0, 1'b1, "pop2");
        step(1'b1, 32'h5, 1'b0, "push5");
        step(1'b1, 32'h6, 1'b0, "push6");
        for (int i = 3; i <= 6; i++) begin
            chk("drain.order", out_data, 32'(i));
            step(1'b0, 32'h0, 1'b1, "drain");
        end

        // Streaming: push and pop every cycle
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b1, "stream");
            chk("stream.count", 32'(count), 32'h1);
            chk("stream.data", out_data, 32'h100 + 32'(i));
        end
        step(1'b0, 32'h0, 1'b1, "stream_end");

        // Overflow: offer a word while full, then drain
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, "ovf_fill");
        step(1'b1, 32'hBAD, 1'b0, "ovf_offer");
        step(1'b1, 32'hBAD, 1'b1, "ovf_offer_pop");
        for (int i = 0; i < 5; i++) begin
            chk("ovf.no_bad", 32'(out_data == 32'hBAD), 32'h0);
            step(1'b0, 32'h0, 1'b1, "ovf_drain");
        end
`ifdef NEGRX_OVF_STICKY_EN
        chk("ovf.sticky", 32'(ovf), 32'h1);
`else
        chk("ovf.tied", 32'(ovf), 32'h0);
`endif

        // Reset in the middle of operation
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + 32'(i), 1'b0, "mid_fill");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'h0);
        chk("midrst.out_data", out_data, 32'h0);
        chk("midrst.count", 32'(count), 32'h0);
        chk("midrst.ovf", 32'(ovf), 32'h0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        mq.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_rst");
        step(1'b1, 32'h77, 1'b0, "push77");
        chk("push77.data", out_data, 32'h77);
        step(1'b0, 32'h0, 1'b1, "pop77");

        // Randomized traffic with varying push/pop pressure
        for (int i = 0; i < 400; i++) begin
            logic v, r;
            int bias;
            bias = (i / 100) % 4;
            v = ($urandom_range(0, 3) < (bias + 1)) ? 1'b1 : 1'b0;
            r = ($urandom_range(0, 3) < (4 - bias)) ? 1'b1 : 1'b0;
            step(v, 32'($urandom), r, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/negedge_word_receiver.md
# negedge_word_receiver

Posedge-side receiving end of the divider's negedge-launched 32-bit datapath: words launched on the falling edge of `clk` are captured on the next rising edge into a small first-word-fall-through queue. The queue is drained by a posedge consumer through a valid/ready handshake. It sits between the divider's negedge output registers and the posedge writeback/control logic. It decouples the consumer from the producer's issue rate and gives a clean full-cycle-domain interface.

## Interface
Parameters:
- `WIDTH`, 32, data word width in bits.
- `DEPTH`, 4, queue entries; must be a power of two and at least 2.

Ports:
- `clk`  input  1  single clock; the producer launches on negedge, this block samples on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  producer word valid (negedge-launched).
- `in_data`  input  WIDTH  producer word (negedge-launched).
- `in_ready`  output  1  queue can accept a word this posedge.
- `out_valid`  output  1  head word available.
- `out_data`  output  WIDTH  head word; 0 when `out_valid`=0.
- `out_ready`  input  1  consumer takes the head word this posedge.
- `count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `ovf`  output  1  sticky overflow flag (see Configuration).

## Operation
- Storage: DEPTH x WIDTH array, write pointer `wp`, read pointer `rp`, both $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy register `count`.
- push = `in_valid` & `in_ready`, sampled at posedge. Writes `in_data` to mem[wp], then wp+1.
- pop = `out_valid` & `out_ready`, sampled at posedge. Advances rp+1.
- `in_ready` = (`count` != DEPTH); `out_valid` = (`count` != 0); both decoded from registered `count` only, with no combinational path from `in_valid` or `out_ready`.
- `out_data` = `out_valid` ? mem[rp] : 0 (first-word-fall-through).
- Count update: push only +1; pop only -1; push and pop together leaves it unchanged; neither leaves it unchanged.
- Full: `in_ready`=0, and any offered word is not stored. Pop proceeds normally, and `in_ready` rises the posedge after the pop.
- Empty: `out_valid`=0, and `out_ready` is ignored (no pointer movement).
- Simultaneous push/pop at count=1 is legal. The head is replaced by the new word, and `out_valid` stays 1.
- Pointer wrap from DEPTH-1 to 0 is seamless, with no bubble.
- Reset (asserted at any time, including mid-transfer): wp=rp=0, `count`=0, `out_valid`=0, `out_data`=0, `in_ready`=1, `ovf`=0. Memory contents are not reset and are never visible, because of the `out_data` gating.

## Timing
- All state updates occur on posedge `clk`. Reset acts immediately on assertion and is released synchronously to the design by the system reset logic.
- Producer inputs have a half-cycle path (negedge launch to posedge capture). No other half-cycle paths exist inside the block.
- Latency: a word pushed at posedge N is visible on `out_data` with `out_valid`=1 after posedge N, so it is poppable at posedge N+1.
- Throughput: one push and one pop per cycle sustained.
- Outputs change only after posedge or on reset assertion.

## Configuration
- `NEGRX_OVF_STICKY_EN` defined:
  - `ovf` is set at the first posedge where `in_valid`=1 and `in_ready`=0, which is a dropped word.
  - Once set, `ovf` stays 1 until reset.
- `NEGRX_OVF_STICKY_EN` undefined:
  - `ovf` is tied to 0 and no flag register is built.
  - Dropped words are still silently discarded.

## Test plan
- Reset/idle: hold `rst_n`=0 then release, with no traffic. Require `count`=0, `out_valid`=0, `out_data`=0, `in_ready`=1 and `ovf`=0.
- Single word: push 0xDEADBEEF with `out_ready`=0. Require `out_valid`=1, `out_data`=0xDEADBEEF and `count`=1 after that posedge. Then pop one cycle, and require `count`=0 and `out_data`=0.
- Fill, drain and wrap:
  - Push 0x1,0x2,0x3,0x4 with DEPTH=4. Require `in_ready`=0 and `count`=4.
  - Pop two, then push 0x5,0x6.
  - Drain and require the order 3,4,5,6 with wrapped pointers.
- Streaming: assert `in_valid` and `out_ready` continuously for 20 words 0x100..0x113. Require `count` to hold at 1 after the first cycle and every word to appear in order with no bubbles.
- Overflow (macro defined): at `count`=4, offer 0xBAD with `out_ready`=0. Require 0xBAD never to appear on `out_data`, and `ovf`=1 persisting through later pops until `rst_n`=0. With the macro undefined, require `ovf`=0 throughout.
- Reset mid-operation: with `count`=3, assert `rst_n`=0 between edges. Require immediate `out_valid`=0, `out_data`=0 and `count`=0, and a subsequent push of 0x77 to read back as 0x77.
